alu_uart_seq: RTL and testbench
===============================

# alu_uart_seq

Host-side sequencer for the ALU operand-loading interface. It takes bytes from the UART receiver (A, then B, then opcode) and drives the ALU's `e1`/`e2`/`e3`/`data` load port. It then captures the ALU result and flags and returns them to the UART transmitter as two bytes (result, then packed flags). It sits between the UART RX/TX pair and the ALU, replacing the switch/button front end.

## Interface
- `DATA_WIDTH`, 8, operand/result byte width.
- `OPCODE_WIDTH`, 6, opcode width; opcode is taken from `rx_data[OPCODE_WIDTH-1:0]` with upper bits forwarded unchanged.
- `TIMEOUT_CYCLES`, 50_000_000, inter-byte timeout (used only with the macro below).

Ports:
- `clk` in 1: single system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in DATA_WIDTH: byte from UART RX, valid when `rx_done` is high.
- `rx_done` in 1: one-cycle pulse, byte received.
- `tx_start` out 1: one-cycle pulse requesting transmission of `tx_data`.
- `tx_data` out DATA_WIDTH: byte to transmit; held stable until matching `tx_done`.
- `tx_done` in 1: one-cycle pulse, byte fully transmitted.
- `alu_e1`, `alu_e2`, `alu_e3` out 1 each: load enables for A, B, Op.
- `alu_data` out DATA_WIDTH: data bus to the ALU.
- `alu_result` in DATA_WIDTH: ALU result.
- `alu_zero`, `alu_carry`, `alu_overflow`, `alu_neg` in 1 each: ALU flags.
- `busy` out 1: high from opcode acceptance until flags byte `tx_done`.

## Operation
- States: `WAIT_A` → `WAIT_B` → `WAIT_OP` → `SETTLE` → `SEND_RES` → `WAIT_RES` → `SEND_FLG` → `WAIT_FLG` → `WAIT_A`.
- In `WAIT_A`/`WAIT_B`/`WAIT_OP`, an `rx_done` does two things on the next edge:
  - registers `rx_data` onto `alu_data`;
  - asserts exactly one of `alu_e1`/`e2`/`e3` for one cycle, then advances state.
- `SETTLE`: one cycle. At its end, `alu_result` goes into `res_q` and the flags go into `flg_q = {{DATA_WIDTH-4{0}}, neg, overflow, carry, zero}` (bit3 = neg, bit0 = zero).
- `SEND_RES`: `tx_data = res_q` and `tx_start` pulses one cycle. `WAIT_RES` then waits for `tx_done`.
- `SEND_FLG`/`WAIT_FLG`: same sequence with `flg_q`. After `tx_done`, the block returns to `WAIT_A` and `busy` drops.
- `rx_done` in `SETTLE` through `WAIT_FLG`: ignored, byte dropped, no state change.
- `tx_done` outside `WAIT_RES`/`WAIT_FLG`: ignored.
- `alu_data` holds its last value between loads; enables are never asserted simultaneously.
- Opcode is not validated; undefined opcodes return whatever the ALU produces (0x00 result).

## Timing
- Reset (async assert, sync deassert at the source): state `WAIT_A`; `tx_start`, `tx_data`, `alu_e1/e2/e3`, `alu_data`, `busy`, `res_q`, `flg_q` all 0.
- Reset mid-transaction aborts without any `tx_start`. ALU registers are not touched.
- Load latency: `rx_done` at cycle N → `alu_eX` high in N+1 only.
- Opcode `rx_done` at N:
  - `alu_e3` at N+1;
  - `busy` high from N+1;
  - `SETTLE` at N+2;
  - `tx_start` (result) at N+3.
- Flags `tx_start` one cycle after the result `tx_done`. `busy` low one cycle after the flags `tx_done`.
- Minimum gap between successive `rx_done` pulses accepted: 1 cycle (back-to-back pulses are each accepted).

## Configuration
- `ALU_UART_SEQ_TIMEOUT_EN` defined:
  - a counter clears on each accepted byte and increments in `WAIT_B`/`WAIT_OP`;
  - on reaching `TIMEOUT_CYCLES-1`, the state returns to `WAIT_A` with no enables asserted;
  - partial loads already in the ALU remain.
- Not defined: no counter exists; `WAIT_B`/`WAIT_OP` wait indefinitely; `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `alu_seq_pkg`: state encoding constants, flag-byte bit positions (`FLG_ZERO=0`, `FLG_CARRY=1`, `FLG_OVF=2`, `FLG_NEG=3`), default `DATA_WIDTH`/`OPCODE_WIDTH`.
- No sub-module is needed; the timeout counter stays inline under the macro.

## Test plan
- Bytes 0x05, 0x03, 0x20 → enables pulse e1, e2, e3 in order with `alu_data` 0x05/0x03/0x20; TX sends 0x08 then 0x00.
- Bytes 0x7F, 0x01, 0x20 → TX 0x80 then 0x0C (neg and overflow set).
- Bytes 0x05, 0x05, 0x22 (SUB) → TX 0x00 then 0x03 (carry = no-borrow, zero).
- `rx_done` with 0xAA during `WAIT_RES` → dropped. Next three bytes 0x0F, 0xF0, 0x25 (OR) → TX 0xFF then 0x08.
- `reset_n` low for 3 cycles after A is loaded → all outputs 0, no `tx_start`. Next 3 bytes are treated as A, B, Op.
- With `ALU_UART_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES=100`: A, then 100 idle cycles → state `WAIT_A`. Bytes 0x02, 0x03, 0x20 → TX 0x05, 0x00.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, flag-byte layout and default widths for alu_uart_seq
package alu_seq_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_OPCODE_WIDTH = 6;
   localparam int FLG_ZERO = 0;
   localparam int FLG_CARRY = 1;
   localparam int FLG_OVF = 2;
   localparam int FLG_NEG = 3;
   typedef enum logic [2:0] {
      WAIT_A, WAIT_B, WAIT_OP, SETTLE, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
   } state_t;
   function automatic logic [3:0] pack_flags(input logic zero, input logic carry, input logic ovf, input logic neg);
      logic [3:0] f;
      f = '0;
      f[FLG_ZERO] = zero;
      f[FLG_CARRY] = carry;
      f[FLG_OVF] = ovf;
      f[FLG_NEG] = neg;
      return f;
   endfunction
endpackage

// File: rtl/alu_uart_seq_if.sv
// alu_uart_seq_if: UART RX/TX and ALU load-port signals seen by the sequencer
interface alu_uart_seq_if
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] rx_data, tx_data, alu_data, alu_result;
   logic rx_done, tx_start, tx_done, busy;
   logic alu_e1, alu_e2, alu_e3;
   logic alu_zero, alu_carry, alu_overflow, alu_neg;
   modport master (
      input rx_data, rx_done, tx_done, alu_result, alu_zero, alu_carry, alu_overflow, alu_neg,
      output tx_start, tx_data, alu_e1, alu_e2, alu_e3, alu_data, busy
   );
   modport slave (
      output rx_data, rx_done, tx_done, alu_result, alu_zero, alu_carry, alu_overflow, alu_neg,
      input tx_start, tx_data, alu_e1, alu_e2, alu_e3, alu_data, busy
   );
endinterface

// File: rtl/alu_uart_seq.sv
// alu_uart_seq: loads A/B/opcode from UART RX into the ALU, returns result and flags over UART TX.
// Define ALU_UART_SEQ_TIMEOUT_EN to abandon a partial load after TIMEOUT_CYCLES idle cycles.
module alu_uart_seq
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
`ifdef ALU_UART_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
   input logic clk,
   input logic reset_n,
   alu_uart_seq_if.master bus
);
   state_t state, state_nxt;
   logic [DATA_WIDTH-1:0] res_q, flg_q;
   logic accept, timeout;
`ifdef ALU_UART_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   logic [TMO_W-1:0] tmo_cnt;
   logic in_wait;
   assign in_wait = state inside {WAIT_B, WAIT_OP};
   assign timeout = in_wait && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tmo_cnt <= '0;
      else tmo_cnt <= (accept || !in_wait) ? '0 : tmo_cnt + TMO_W'(1);
   end
`else
   assign timeout = 1'b0;
`endif
   // WAIT_OP is held for the cycle alu_e3 is high so SETTLE sees the newly loaded opcode
   always_comb begin
      state_nxt = state;
      accept = 1'b0;
      case (state)
         WAIT_A: begin
            accept = bus.rx_done;
            state_nxt = bus.rx_done ? WAIT_B : WAIT_A;
         end
         WAIT_B: begin
            accept = bus.rx_done;
            state_nxt = bus.rx_done ? WAIT_OP : timeout ? WAIT_A : WAIT_B;
         end
         WAIT_OP: begin
            accept = bus.rx_done && !bus.alu_e3;
            state_nxt = bus.alu_e3 ? SETTLE : (!bus.rx_done && timeout) ? WAIT_A : WAIT_OP;
         end
         SETTLE: state_nxt = SEND_RES;
         SEND_RES: state_nxt = WAIT_RES;
         WAIT_RES: state_nxt = bus.tx_done ? SEND_FLG : WAIT_RES;
         SEND_FLG: state_nxt = WAIT_FLG;
         WAIT_FLG: state_nxt = bus.tx_done ? WAIT_A : WAIT_FLG;
         default: state_nxt = WAIT_A;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= WAIT_A;
         bus.alu_e1 <= 1'b0;
         bus.alu_e2 <= 1'b0;
         bus.alu_e3 <= 1'b0;
         bus.alu_data <= '0;
         res_q <= '0;
         flg_q <= '0;
      end else begin
         state <= state_nxt;
         bus.alu_e1 <= accept && state == WAIT_A;
         bus.alu_e2 <= accept && state == WAIT_B;
         bus.alu_e3 <= accept && state == WAIT_OP;
         if (accept) bus.alu_data <= (state == WAIT_OP) ? {bus.rx_data[DATA_WIDTH-1:OPCODE_WIDTH], bus.rx_data[OPCODE_WIDTH-1:0]} : bus.rx_data;
         if (state == SETTLE) begin
            res_q <= bus.alu_result;
            flg_q <= {{(DATA_WIDTH-4){1'b0}}, pack_flags(bus.alu_zero, bus.alu_carry, bus.alu_overflow, bus.alu_neg)};
         end
      end
   end
   assign bus.tx_start = state inside {SEND_RES, SEND_FLG};
   assign bus.tx_data = state inside {SEND_FLG, WAIT_FLG} ? flg_q : res_q;
   assign bus.busy = bus.alu_e3 || state inside {SETTLE, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG};
endmodule

// File: tb/tb_alu_uart_seq.sv
// tb_alu_uart_seq: random A/B/opcode transactions checked against a byte-level ALU/UART model
module tb_alu_uart_seq;
   import alu_seq_pkg::*;
   typedef struct {
      int cyc;
      logic [2:0] en;
      logic [7:0] d;
   } ld_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   ld_t ld_q[$];
   logic [7:0] tx_q[$];
   int tx_cyc_q[$];
   int done_cyc_q[$];
   int busy_rise = -1;
   int busy_fall = -1;
   logic busy_d = 1'b0;
   logic [7:0] ra = '0, rb = '0, rop = '0, held;
   logic [15:0] alu_out;
   alu_uart_seq_if #(.DATA_WIDTH(8)) bus();
`ifdef ALU_UART_SEQ_TIMEOUT_EN
   alu_uart_seq #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
   alu_uart_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // reference ALU: returns {result, 0000, neg, ovf, carry, zero}
   function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      logic [8:0] s;
      logic [7:0] r;
      logic c, v;
      s = '0;
      c = 1'b0;
      v = 1'b0;
      case (op[5:0])
         6'h20: begin s = {1'b0, a} + {1'b0, b}; c = s[8]; v = a[7] == b[7] && s[7] != a[7]; end
         6'h22: begin s = {1'b0, a} - {1'b0, b}; c = a >= b; v = a[7] != b[7] && s[7] != a[7]; end
         6'h24: s = {1'b0, a & b};
         6'h25: s = {1'b0, a | b};
         6'h26: s = {1'b0, a ^ b};
         default: s = '0;
      endcase
      r = s[7:0];
      return {r, 4'h0, r[7], v, c, r == 8'h00};
   endfunction
   always @(posedge clk) begin
      if (bus.alu_e1) ra <= bus.alu_data;
      if (bus.alu_e2) rb <= bus.alu_data;
      if (bus.alu_e3) rop <= bus.alu_data;
   end
   assign alu_out = ref_alu(ra, rb, rop);
   assign bus.alu_result = alu_out[15:8];
   assign {bus.alu_neg, bus.alu_overflow, bus.alu_carry, bus.alu_zero} = alu_out[3:0];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      ld_t e;
      if (bus.alu_e1 || bus.alu_e2 || bus.alu_e3) begin
         e.cyc = cyc;
         e.en = {bus.alu_e3, bus.alu_e2, bus.alu_e1};
         e.d = bus.alu_data;
         ld_q.push_back(e);
      end
      if (bus.tx_start) begin
         tx_q.push_back(bus.tx_data);
         tx_cyc_q.push_back(cyc);
      end
      if (bus.busy && !busy_d) busy_rise = cyc;
      if (!bus.busy && busy_d) busy_fall = cyc;
      busy_d = bus.busy;
   end
   // UART TX stand-in: acknowledges each tx_start after a random transmit time
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start) begin
            held = bus.tx_data;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 chk("tx_hold", bus.tx_data, held);
            bus.tx_done = 1'b1;
            done_cyc_q.push_back(cyc);
            @(posedge clk);
            #1 bus.tx_done = 1'b0;
         end
      end
   end
   task automatic send_byte(input logic [7:0] d, input int gap);
      bus.rx_data = d;
      bus.rx_done = 1'b1;
      @(posedge clk);
      #1 bus.rx_done = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int gap, input bit inject, input bit skip_a);
      logic [15:0] exp;
      logic [7:0] bytes [3];
      int op_cyc, k, n_ld, idx;
      exp = ref_alu(a, b, op);
      bytes = '{a, b, op};
      ld_q.delete();
      tx_q.delete();
      tx_cyc_q.delete();
      done_cyc_q.delete();
      busy_rise = -1;
      busy_fall = -1;
      if (!skip_a) send_byte(a, gap);
      send_byte(b, gap);
      op_cyc = cyc;
      send_byte(op, 0);
      if (inject) begin
         for (k = 0; k < 50 && tx_q.size() == 0; k++) @(negedge clk);
         @(posedge clk);
         #1 bus.rx_data = 8'hAA;
         bus.rx_done = 1'b1;
         @(posedge clk);
         #1 bus.rx_done = 1'b0;
      end
      for (k = 0; k < 300 && (tx_q.size() < 2 || bus.busy); k++) @(negedge clk);
      @(posedge clk);
      #1 chk("txn_bound", 32'(k < 300), 1);
      n_ld = skip_a ? 2 : 3;
      chk("ld_count", ld_q.size(), n_ld);
      for (int i = 0; i < n_ld && i < ld_q.size(); i++) begin
         idx = i + 3 - n_ld;
         chk("ld_en", 32'(ld_q[i].en), 32'(1) << idx);
         chk("ld_data", 32'(ld_q[i].d), 32'(bytes[idx]));
      end
      if (ld_q.size() == n_ld) chk("e3_latency", ld_q[n_ld-1].cyc, op_cyc + 1);
      chk("tx_count", tx_q.size(), 2);
      if (tx_q.size() == 2 && done_cyc_q.size() == 2) begin
         chk("tx_result", 32'(tx_q[0]), 32'(exp[15:8]));
         chk("tx_flags", 32'(tx_q[1]), 32'(exp[7:0]));
         chk("res_latency", tx_cyc_q[0], op_cyc + 3);
         chk("flg_latency", tx_cyc_q[1], done_cyc_q[0] + 1);
         chk("busy_rise", busy_rise, op_cyc + 1);
         chk("busy_fall", busy_fall, done_cyc_q[1] + 1);
      end
   endtask
   initial begin
      logic [7:0] ops [6];
      logic [7:0] op;
      ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h3F};
      bus.rx_data = '0;
      bus.rx_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {bus.tx_start, bus.tx_data, bus.alu_e1, bus.alu_e2, bus.alu_e3, bus.alu_data, bus.busy}, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      run_txn(8'h05, 8'h03, 8'h20, 0, 0, 0);
      run_txn(8'h7F, 8'h01, 8'h20, 1, 0, 0);
      run_txn(8'h05, 8'h05, 8'h22, 2, 0, 0);
      run_txn(8'h12, 8'h34, 8'h26, 0, 1, 0);
      run_txn(8'h0F, 8'hF0, 8'h25, 0, 0, 0);
      tx_q.delete();
      send_byte(8'h11, 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_outs", {bus.tx_start, bus.tx_data, bus.alu_e1, bus.alu_e2, bus.alu_e3, bus.alu_data, bus.busy}, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_tx", tx_q.size(), 0);
      @(posedge clk);
      #1;
      run_txn(8'h0A, 8'h03, 8'h20, 0, 0, 0);
      send_byte(8'h44, 0);
      repeat (110) begin @(posedge clk); #1; end
`ifdef ALU_UART_SEQ_TIMEOUT_EN
      run_txn(8'h02, 8'h03, 8'h20, 0, 0, 0);
`else
      run_txn(8'h44, 8'h03, 8'h20, 0, 0, 1);
`endif
      for (int t = 0; t < 20; t++) begin
         op = ops[$urandom_range(0, 5)] | 8'($urandom_range(0, 3) << 6);
         run_txn(8'($urandom), 8'($urandom), op, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end
endmodule
